// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with registered read port, programmable almost-full/almost-empty
// thresholds and a sticky overflow/underflow error flag.
module fifo_umbral #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   umbral_af,
  input  logic [ADDR_WIDTH:0]   umbral_ae,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid, r_error;
  logic                  w_push_ok, w_pop_ok;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  assign full         = r_count == CNT_FULL;
  assign empty        = r_count == '0;
  assign almost_full  = r_count >= umbral_af;
  assign almost_empty = r_count <= umbral_ae;
  assign count        = r_count;
  assign data_out     = r_data_out;
  assign valid_out    = r_valid;
  assign error        = r_error;

  // a pop frees a slot in the same edge, so a full FIFO still accepts push+pop
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok) w_count_nxt = r_count + CNT_ONE;
    else if (w_pop_ok && !w_push_ok) w_count_nxt = r_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_valid <= w_pop_ok;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
      end
      if ((push && !w_push_ok) || (pop && !w_pop_ok)) r_error <= 1'b1;
    end
  end
endmodule

// File: doc/fifo_umbral.md
FIFO_UMBRAL -- requirements
Module: fifo_umbral

Interface
REQ-001 Parameter DATA_WIDTH, default 10, bit width of each stored word.
REQ-002 Parameter ADDR_WIDTH, default 3, pointer width; DEPTH = 2**ADDR_WIDTH (default 8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low; clears all state while 0.
REQ-005 push  input  1  write request; data_in written at the rising edge when accepted.
REQ-006 pop  input  1  read request from the arbitration stage.
REQ-007 data_in  input  DATA_WIDTH  word to store.
REQ-008 umbral_af  input  ADDR_WIDTH+1  almost-full threshold (occupancy count).
REQ-009 umbral_ae  input  ADDR_WIDTH+1  almost-empty threshold (occupancy count).
REQ-010 data_out  output  DATA_WIDTH  registered read data.
REQ-011 valid_out  output  1  high for one cycle when data_out holds a newly popped word.
REQ-012 full, empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags feeding the arbiter.
REQ-014 error  output  1  sticky overflow/underflow indicator.
REQ-015 count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-016 Storage SHALL be a DEPTH x DATA_WIDTH register array with write pointer wr_ptr and read pointer rd_ptr, each ADDR_WIDTH bits, wrapping DEPTH-1 -> 0.
REQ-017 Push accepted when push=1 and (full=0 or pop accepted same cycle); accepted push writes mem[wr_ptr] and increments wr_ptr.
REQ-018 Pop accepted when pop=1 and empty=0; accepted pop loads data_out <= mem[rd_ptr], increments rd_ptr, and sets valid_out=1 on the next cycle; 1-cycle read latency.
REQ-019 valid_out SHALL be 0 in any cycle following a non-accepted pop; data_out SHALL hold its last value when no pop is accepted.
REQ-020 count: +1 on push only, -1 on pop only, unchanged on simultaneous accepted push and pop.
REQ-021 Simultaneous push and pop with full=1: both accepted, count stays DEPTH.
REQ-022 Simultaneous push and pop with empty=1: push accepted, pop rejected, count becomes 1, valid_out=0 next cycle, error set.
REQ-023 Push with full=1 and no pop: word dropped, pointers/count unchanged, error set.
REQ-024 Pop with empty=1: rejected, error set.
REQ-025 error SHALL remain 1 until reset is asserted.
REQ-026 full, empty, almost_full, almost_empty SHALL be combinational from registered count: almost_full = (count >= umbral_af); almost_empty = (count <= umbral_ae).
REQ-027 Thresholds SHALL be sampled continuously; changing them changes flags in the same cycle without affecting stored data.
REQ-028 Threshold values above DEPTH SHALL be legal: umbral_af > DEPTH keeps almost_full=0; umbral_ae >= DEPTH keeps almost_empty=1.

Reset
REQ-029 On reset=0 (asynchronous, any time including mid-transfer): wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0; memory contents need not be cleared.
REQ-030 During reset: empty=1, full=0, almost_empty=1 (for umbral_ae >= 0), almost_full=(umbral_af == 0).
REQ-031 First accepted operation SHALL occur at the first rising edge with reset=1.

Verification
REQ-032 Fill: reset, umbral_af=6, 8 pushes of 0x001..0x008 -> count 1..8, almost_full rises when count=6, full=1 after 8th, error=0.
REQ-033 Drain/order: from full, 8 pops -> data_out 0x001..0x008 each one cycle after pop with valid_out=1, empty=1 after last, almost_empty=1 when count <= umbral_ae (umbral_ae=2).
REQ-034 Wrap-around: 5 pushes, 5 pops, 6 pushes, 6 pops -> read order matches write order across index 7->0, error=0.
REQ-035 Overflow/underflow: push when full without pop -> count stays 8, error=1, later pops return the original 8 words; after reset, pop on empty -> error=1, valid_out=0.
REQ-036 Simultaneous: full with push+pop -> count 8, oldest word out, new word at tail; empty with push+pop -> count 1, valid_out=0, error=1.
REQ-037 Async reset mid-operation: assert reset=0 between clock edges with count=4 -> count, pointers, valid_out, error clear immediately without waiting for clk; empty=1.
